// File: rtl/reg_bank4.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank4
// Purpose  : Four-entry register bank fed through an in-order write buffer
//            that retires one entry per granted commit slot.
// Revision : 1.0
// ============================================================================
module reg_bank4 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit_en,
  input  logic             flush,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic [WIDTH-1:0] out_3,
  output logic [WIDTH-1:0] out_4,
  output logic [2:0]       pending,
  output logic             busy
);

  localparam int         c_ptr_w = $clog2(DEPTH);
  localparam logic [2:0] c_depth = 3'(DEPTH);

  logic [1:0]         r_fifo_addr [DEPTH];
  logic [WIDTH-1:0]   r_fifo_data [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [2:0]         r_pending;
  logic               r_busy;
  logic [WIDTH-1:0]   r_regs [4];

  logic               w_accept;
  logic               w_commit;
  logic [2:0]         w_pending_nxt;

  // Ready looks only at occupancy so a full buffer never accepts, even while committing
  assign wr_ready = (r_pending < c_depth) && !rst;
  assign w_accept = wr_valid && wr_ready && !flush;
  assign w_commit = commit_en && (r_pending != 3'd0) && !flush;

  always_comb begin
    w_pending_nxt = r_pending;
    if (flush) begin
      w_pending_nxt = 3'd0;
    end else if (w_accept && !w_commit) begin
      w_pending_nxt = r_pending + 3'd1;
    end else if (!w_accept && w_commit) begin
      w_pending_nxt = r_pending - 3'd1;
    end
  end

  // Buffer storage needs no reset; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_fifo_addr[r_wr_ptr] <= wr_addr;
      r_fifo_data[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_pending <= 3'd0;
      r_busy    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_pending <= w_pending_nxt;
      r_busy    <= (w_pending_nxt != 3'd0);
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_accept) begin
          r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
        end
        if (w_commit) begin
          r_rd_ptr                        <= r_rd_ptr + c_ptr_w'(1);
          r_regs[r_fifo_addr[r_rd_ptr]]   <= r_fifo_data[r_rd_ptr];
        end
      end
    end
  end

  assign out_1   = r_regs[0];
  assign out_2   = r_regs[1];
  assign out_3   = r_regs[2];
  assign out_4   = r_regs[3];
  assign pending = r_pending;
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank4.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank4
// Purpose  : Directed vector bench for reg_bank4 (DEPTH = 2).
// Revision : 1.0
// ============================================================================
module tb_reg_bank4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        commit_en;
  logic        flush;
  logic [15:0] out_1, out_2, out_3, out_4;
  logic [2:0]  pending;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bank4 #(.WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit_en(commit_en), .flush(flush),
    .out_1(out_1), .out_2(out_2), .out_3(out_3), .out_4(out_4),
    .pending(pending), .busy(busy)
  );

  typedef struct {
    logic        wv;
    logic [1:0]  addr;
    logic [15:0] data;
    logic        ce;
    logic        fl;
    logic        exp_ready;
    logic [2:0]  exp_pend;
    logic [15:0] exp_o1, exp_o2, exp_o3, exp_o4;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wv, input logic [1:0] a, input logic [15:0] d,
                       input logic ce, input logic fl);
    wr_valid = wv; wr_addr = a; wr_data = d; commit_en = ce; flush = fl;
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                          input logic [15:0] e3, input logic [15:0] e4);
    chk({tag, ".out_1"}, 32'(out_1), 32'(e1));
    chk({tag, ".out_2"}, 32'(out_2), 32'(e2));
    chk({tag, ".out_3"}, 32'(out_3), 32'(e3));
    chk({tag, ".out_4"}, 32'(out_4), 32'(e4));
  endtask

  initial begin
    // Shared sequence: single write, ordering, fill/stall, flush priority
    //            wv addr data      ce fl rdy pend o1       o2       o3       o4
    vecs[0]  = '{1, 2, 16'hBEEF, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{0, 0, 16'h0000, 1, 0, 1, 0, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[2]  = '{1, 1, 16'h1111, 1, 0, 1, 1, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[3]  = '{1, 1, 16'h2222, 0, 0, 1, 2, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[4]  = '{1, 3, 16'h3333, 0, 0, 0, 2, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[5]  = '{1, 3, 16'h3333, 1, 0, 0, 1, 16'h0000, 16'h1111, 16'hBEEF, 16'h0000};
    vecs[6]  = '{1, 3, 16'h3333, 1, 0, 1, 1, 16'h0000, 16'h2222, 16'hBEEF, 16'h0000};
    vecs[7]  = '{0, 0, 16'h0000, 1, 0, 1, 0, 16'h0000, 16'h2222, 16'hBEEF, 16'h3333};
    vecs[8]  = '{1, 0, 16'hAAAA, 0, 0, 1, 1, 16'h0000, 16'h2222, 16'hBEEF, 16'h3333};
    vecs[9]  = '{1, 1, 16'h5555, 0, 0, 1, 2, 16'h0000, 16'h2222, 16'hBEEF, 16'h3333};
    vecs[10] = '{1, 2, 16'h7777, 1, 1, 0, 0, 16'h0000, 16'h2222, 16'hBEEF, 16'h3333};
    vecs[11] = '{1, 2, 16'h7777, 1, 1, 1, 0, 16'h0000, 16'h2222, 16'hBEEF, 16'h3333};
    vecs[12] = '{1, 2, 16'h7777, 0, 0, 1, 1, 16'h0000, 16'h2222, 16'hBEEF, 16'h3333};
    vecs[13] = '{0, 0, 16'h0000, 1, 0, 1, 0, 16'h0000, 16'h2222, 16'h7777, 16'h3333};

    rst = 1'b1;
    drive(0, 0, 16'h0, 0, 0);
    #1;
    chk("reset.ready", 32'(wr_ready), 32'd0);
    chk("reset.pending", 32'(pending), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk_outs("reset", 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset.ready", 32'(wr_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].wv, vecs[i].addr, vecs[i].data, vecs[i].ce, vecs[i].fl);
      #1;
      chk($sformatf("vec%0d.ready", i), 32'(wr_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.pending", i), 32'(pending), 32'(vecs[i].exp_pend));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].exp_pend != 3'd0));
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_o1, vecs[i].exp_o2,
               vecs[i].exp_o3, vecs[i].exp_o4);
    end

    // Streaming with wrap-around: 8 writes, commit held high
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(1, 2'(k % 4), 16'(k + 1), 1, 0);
      #1;
      chk($sformatf("stream%0d.ready", k), 32'(wr_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d.pending", k), 32'(pending), 32'd1);
      if (k > 0) begin
        case ((k - 1) % 4)
          0: chk($sformatf("stream%0d.out_1", k), 32'(out_1), 32'(k));
          1: chk($sformatf("stream%0d.out_2", k), 32'(out_2), 32'(k));
          2: chk($sformatf("stream%0d.out_3", k), 32'(out_3), 32'(k));
          default: chk($sformatf("stream%0d.out_4", k), 32'(out_4), 32'(k));
        endcase
      end
    end
    @(negedge clk);
    drive(0, 0, 16'h0, 1, 0);
    @(posedge clk);
    #1;
    chk("stream_end.pending", 32'(pending), 32'd0);
    chk_outs("stream_end", 16'h0005, 16'h0006, 16'h0007, 16'h0008);

    // Asynchronous reset mid-stream with two entries buffered
    @(negedge clk);
    drive(1, 0, 16'h1234, 0, 0);
    @(negedge clk);
    drive(1, 1, 16'h5678, 0, 0);
    @(negedge clk);
    drive(0, 0, 16'h0, 0, 0);
    chk("pre_async.pending", 32'(pending), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async.ready", 32'(wr_ready), 32'd0);
    chk("async.pending", 32'(pending), 32'd0);
    chk("async.busy", 32'(busy), 32'd0);
    chk_outs("async", 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_release.ready", 32'(wr_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("async_release.pending", 32'(pending), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/reg_bank4.md
# reg_bank4

Four-entry, 16-bit register bank with a buffered write port. It sits directly upstream of the 4:1 operand selector. It drives that selector's four 16-bit data inputs from its four registers. Writes are accepted through a valid/ready handshake into a small in-order FIFO and are retired into the registers only when the pipeline grants a commit slot.

## Interface

Parameters:
- WIDTH, 16, data width of each register and of the write data.
- DEPTH, 2, write-buffer entries; legal values 2 or 4.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; asynchronous, active-high.
- wr_valid  input  1  write request present.
- wr_ready  output  1  buffer can accept a write this cycle.
- wr_addr  input  2  destination register index 0..3.
- wr_data  input  WIDTH  write data.
- commit_en  input  1  permission to retire the buffer head this cycle.
- flush  input  1  discard all buffered, uncommitted writes.
- out_1  output  WIDTH  register 0 contents.
- out_2  output  WIDTH  register 1 contents.
- out_3  output  WIDTH  register 2 contents.
- out_4  output  WIDTH  register 3 contents.
- pending  output  3  number of buffered entries, 0..DEPTH.
- busy  output  1  high when pending != 0.

## Operation

- Reset:
  - Asynchronous; takes effect immediately when rst rises, mid-operation included.
  - All four registers clear to 0, so out_1..out_4 = 0.
  - Buffer empty; read/write pointers clear to 0; pending = 0; busy = 0.
  - wr_ready = 0 while rst is high.
- Accept:
  - wr_ready = (pending < DEPTH) and not rst.
  - A write is accepted on a rising edge where wr_valid and wr_ready are both high.
  - {wr_addr, wr_data} is stored at the tail.
- Commit:
  - Occurs on a rising edge where commit_en = 1 and pending > 0.
  - The head entry's data is written into register[addr], then the head is popped.
  - At most one commit per cycle.
  - commit_en with pending = 0 is a no-op.
- Ordering: strictly FIFO. Two buffered writes to the same address retire in order, so the last accepted value wins.
- No bypass:
  - An entry accepted at an edge cannot commit at that same edge.
  - A write into an empty buffer with commit_en high in the same cycle is stored, not retired.
- Simultaneous accept and commit:
  - Both occur; pending is unchanged.
  - Allowed only when wr_ready = 1. A full buffer does not accept even if it commits that cycle, because wr_ready depends on pending only.
- Flush:
  - Synchronous; priority over accept and commit in the same cycle.
  - Buffer empties, pointers reset, pending = 0.
  - Registers keep their values; a commit requested in the flush cycle is dropped.
  - A write offered in the flush cycle is not accepted, even though wr_ready may read 1. The upstream must hold wr_valid and retry.
- Pointers:
  - log2(DEPTH)-bit each, wrapping modulo DEPTH.
  - pending is kept as a separate counter, so full and empty are unambiguous.
- wr_addr is always legal (2 bits). No range checks.

## Timing

- All state changes on the rising edge of clk, except reset.
- out_1..out_4 are driven directly from flops; no combinational path from any input.
- wr_ready is combinational from pending and rst only; there is no path from wr_valid.
- Minimum latency, accept to visible:
  - Write accepted at edge k.
  - Commit at edge k+1 if commit_en is high in the cycle between.
  - New value appears on out_x immediately after edge k+1.
- Back-to-back: with commit_en held high and wr_valid held high, sustained throughput is one write per cycle. pending stays at 1 after the first accept.
- pending and busy are registered and update on the same edge as the buffer.

## Test plan

- Reset / idle:
  - Stimulus: assert rst mid-stream with pending = 2.
  - Response: out_1..out_4 = 0, pending = 0 and wr_ready = 0 immediately, without waiting for a clock edge. After rst falls, wr_ready = 1.
- Single write:
  - Stimulus: write addr 2, data 0xBEEF at edge k; commit_en = 1 in the next cycle.
  - Response: out_3 = 0xBEEF after edge k+1; the other outputs are unchanged.
- Fill and stall:
  - Stimulus: DEPTH=2, commit_en = 0; offer three writes.
  - Response: the first two are accepted, pending = 2, wr_ready = 0. The third is held, then accepted one edge after the first commit.
- Ordering, same address:
  - Stimulus: accept addr 1 = 0x1111, then addr 1 = 0x2222; commit both.
  - Response: out_2 = 0x1111 after the first commit and 0x2222 after the second.
- Flush priority:
  - Stimulus: pending = 2 holding addr 0 = 0xAAAA; assert flush together with commit_en and wr_valid.
  - Response: pending = 0 and out_1 unchanged. The write offered in the flush cycle is not accepted; the upstream holds wr_valid and it is accepted on the following edge.
- Streaming with wrap-around:
  - Stimulus: 8 consecutive writes to addr 0..3 with values 0x0001..0x0008; commit_en held high.
  - Response:
    - One accept and one commit per edge after the first.
    - The pointers wrap without loss.
    - Final values: out_1 = 0x0005, out_2 = 0x0006, out_3 = 0x0007, out_4 = 0x0008.
